up_down_counter_fsm: RTL and testbench

Consumes the three debounced button levels and the shared 1 ms `tick` strobe, and runs a run/stop, up/down decimal counter. It sits directly downstream of the button debouncer: it converts debounced levels into single-cycle rising-edge events and drives a three-state FSM. The FSM steps a 0..CNT_MAX counter once every TICK_DIV ticks. Its count output feeds the FND display path.

---
 rtl/counter_pkg.sv | 19 +
 rtl/edge_detect.sv | 33 +++
 rtl/up_down_counter_fsm.sv | 145 ++++++++++++++
 tb/tb_up_down_counter_fsm.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the run/stop, up/down decimal counter.
//   CNT_W    : width of the count datapath
//   BTN_*    : bit positions of the debounced button vector
//   state_t  : FSM state encoding (STOP=0, UP=1, DOWN=2; 3 unused)
package counter_pkg;

    localparam int unsigned CNT_W = 14;

    localparam int unsigned BTN_RUN = 0;
    localparam int unsigned BTN_DIR = 1;
    localparam int unsigned BTN_CLR = 2;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a vector of debounced levels.
//   clk   : system clock
//   rst   : synchronous, active-high reset
//   level : debounced input levels
//   rise  : one-cycle pulse per bit on a 0->1 transition (combinational)
module edge_detect #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    always_comb begin
        prev_d = level;
    end

    // The previous-level register keeps tracking the input during reset, so a
    // button held through reset release is seen as already high and gives no
    // edge until it is released and pressed again. With all buttons released
    // it settles to zero.
    always_ff @(posedge clk) begin
        prev_q <= prev_d;
    end

    // No events are reported while reset is asserted.
    assign rise = level & ~prev_q & {WIDTH{~rst}};

endmodule

// File: rtl/up_down_counter_fsm.sv
// Run/stop, up/down decimal counter driven by debounced buttons.
//   clk_100Mhz : system clock
//   rst        : synchronous, active-high reset
//   tick       : 1 ms one-cycle strobe
//   btnDb      : debounced buttons; [0] run/stop, [1] direction, [2] clear
//   count      : current count, 0..CNT_MAX
//   state      : FSM state, STOP=0, UP=1, DOWN=2
//   dirDown    : direction memory, 1 = down
//   step       : one-cycle pulse when count takes a stepped value
module up_down_counter_fsm
    import counter_pkg::*;
#(
    parameter int unsigned CNT_MAX  = 9999,
    parameter int unsigned TICK_DIV = 100
) (
    input  logic             clk_100Mhz,
    input  logic             rst,
    input  logic             tick,
    input  logic [2:0]       btnDb,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state,
    output logic             dirDown,
    output logic             step
);

    localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(CNT_MAX);

    logic [2:0] rise;

    edge_detect #(
        .WIDTH(3)
    ) u_edge_detect (
        .clk  (clk_100Mhz),
        .rst  (rst),
        .level(btnDb),
        .rise (rise)
    );

    // Clear takes priority over run/stop and direction in the same cycle.
    logic clr_ev;
    logic dir_ev;
    logic run_ev;

    assign clr_ev = rise[BTN_CLR];
    assign dir_ev = rise[BTN_DIR] & ~clr_ev;
    assign run_ev = rise[BTN_RUN] & ~clr_ev;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [PS_W-1:0]  prescale_q, prescale_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             step_q, step_d;

    logic running;
    logic step_due;

    // Prescaler and stepping follow the registered state, so an edge leaving
    // STOP does not count a coincident tick, and a step coincident with a
    // stop edge still happens.
    assign running  = (state_q != ST_STOP);
    assign step_due = tick & running & (prescale_q == PS_LAST);

    // FSM next state: direction toggle applied first, then run/stop
    // evaluated against the toggled direction.
    always_comb begin
        dir_d   = dir_q ^ dir_ev;
        state_d = state_q;
        if (dir_ev) begin
            case (state_q)
                ST_UP:   state_d = ST_DOWN;
                ST_DOWN: state_d = ST_UP;
                default: state_d = state_q;
            endcase
        end
        if (run_ev) begin
            if (state_q == ST_STOP) begin
                state_d = dir_d ? ST_DOWN : ST_UP;
            end else begin
                state_d = ST_STOP;
            end
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state_q <= ST_STOP;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    // Prescaler holds in STOP so a resumed run finishes the partial period.
    always_comb begin
        prescale_d = prescale_q;
        if (clr_ev) begin
            prescale_d = '0;
        end else if (tick && running) begin
            prescale_d = step_due ? '0 : prescale_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end

    // Counter with explicit compare-and-wrap at 0 and CNT_MAX.
    always_comb begin
        count_d = count_q;
        step_d  = 1'b0;
        if (clr_ev) begin
            count_d = '0;
        end else if (step_due) begin
            step_d = 1'b1;
            if (state_q == ST_UP) begin
                count_d = (count_q == CNT_MAX_C) ? '0 : count_q + CNT_W'(1);
            end else begin
                count_d = (count_q == '0) ? CNT_MAX_C : count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            count_q <= '0;
            step_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            step_q  <= step_d;
        end
    end

    assign count   = count_q;
    assign state   = state_q;
    assign dirDown = dir_q;
    assign step    = step_q;

endmodule

// File: tb/tb_up_down_counter_fsm.sv
// Directed bench for up_down_counter_fsm with CNT_MAX=9, TICK_DIV=2 and a
// tick every 10 clocks.
module tb_up_down_counter_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [2:0]  btnDb;
    logic [13:0] count;
    logic [1:0]  state;
    logic        dirDown;
    logic        step;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned step_cnt = 0;
    int unsigned bad;
    logic        last_step;

    always #5 clk = ~clk;

    up_down_counter_fsm #(
        .CNT_MAX (9),
        .TICK_DIV(2)
    ) dut (
        .clk_100Mhz(clk),
        .rst       (rst),
        .tick      (tick),
        .btnDb     (btnDb),
        .count     (count),
        .state     (state),
        .dirDown   (dirDown),
        .step      (step)
    );

    always @(negedge clk) begin
        if (step === 1'b1) step_cnt = step_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        cyc();
        last_step = step;
        tick = 1'b0;
        repeat (9) cyc();
    endtask

    task automatic press(input logic [2:0] mask);
        btnDb = mask;
        cyc();
        btnDb = 3'b000;
        cyc();
    endtask

    initial begin
        rst   = 1'b1;
        tick  = 1'b0;
        btnDb = 3'b000;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_dir", 32'(dirDown), 0);
        check_eq("rst_step", 32'(step), 0);

        // Run press, held for 50 cycles: exactly one transition.
        btnDb = 3'b001;
        cyc();
        check_eq("run_up", 32'(state), 1);
        bad = 0;
        repeat (50) begin
            cyc();
            if (state !== 2'd1) bad = bad + 1;
        end
        check_eq("hold_single", bad, 0);
        btnDb = 3'b000;
        cyc();

        step_cnt = 0;
        repeat (4) tick_pulse();
        check_eq("four_ticks_count", 32'(count), 2);
        check_eq("four_ticks_steps", step_cnt, 2);

        // Up to 9, then wrap to 0.
        repeat (14) tick_pulse();
        check_eq("up_to_9", 32'(count), 9);
        repeat (2) tick_pulse();
        check_eq("up_wrap", 32'(count), 0);
        check_eq("wrap_step", 32'(last_step), 1);
        press(3'b010);
        check_eq("dir_to_down", 32'(state), 2);
        check_eq("dir_mem_1", 32'(dirDown), 1);
        repeat (2) tick_pulse();
        check_eq("down_wrap", 32'(count), 9);

        // Direction in STOP.
        press(3'b001);
        check_eq("stop", 32'(state), 0);
        press(3'b010);
        check_eq("stop_dir0", 32'(dirDown), 0);
        press(3'b010);
        check_eq("stop_dir1", 32'(dirDown), 1);
        check_eq("stop_stays", 32'(state), 0);
        press(3'b001);
        check_eq("resume_down", 32'(state), 2);
        press(3'b001);
        press(3'b010);
        check_eq("pre_simul_dir", 32'(dirDown), 0);
        press(3'b011);
        check_eq("simul_dir", 32'(dirDown), 1);
        check_eq("simul_state", 32'(state), 2);
        check_eq("no_step_count", 32'(count), 9);

        // Clear coincident with terminal tick and a run edge.
        press(3'b010);
        check_eq("back_up", 32'(state), 1);
        press(3'b100);
        check_eq("clr_count", 32'(count), 0);
        check_eq("clr_keeps_state", 32'(state), 1);
        repeat (11) tick_pulse();
        check_eq("at_5", 32'(count), 5);
        btnDb = 3'b101;
        tick  = 1'b1;
        cyc();
        check_eq("clr_tick_count", 32'(count), 0);
        check_eq("clr_tick_step", 32'(step), 0);
        check_eq("clr_tick_state", 32'(state), 1);
        btnDb = 3'b000;
        tick  = 1'b0;
        repeat (9) cyc();

        // Partial prescale period survives STOP.
        tick_pulse();
        check_eq("half_period", 32'(count), 0);
        press(3'b001);
        tick_pulse();
        check_eq("stopped_hold_count", 32'(count), 0);
        check_eq("stopped_state", 32'(state), 0);
        press(3'b001);
        check_eq("resume_up", 32'(state), 1);
        tick_pulse();
        check_eq("resume_step", 32'(count), 1);
        check_eq("resume_step_pulse", 32'(last_step), 1);
        check_eq("step_one_cycle", 32'(step), 0);

        // Reset mid-run with a button held through reset release.
        press(3'b010);
        tick_pulse();
        btnDb = 3'b001;
        rst   = 1'b1;
        cyc();
        check_eq("midrst_count", 32'(count), 0);
        check_eq("midrst_state", 32'(state), 0);
        check_eq("midrst_dir", 32'(dirDown), 0);
        check_eq("midrst_step", 32'(step), 0);
        rst = 1'b0;
        repeat (3) cyc();
        check_eq("held_no_edge", 32'(state), 0);
        btnDb = 3'b000;
        cyc();
        press(3'b001);
        check_eq("post_rst_up", 32'(state), 1);
        tick_pulse();
        check_eq("prescale_abandoned", 32'(count), 0);
        tick_pulse();
        check_eq("post_rst_step", 32'(count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
